dmem_responder: RTL

//  Data-side memory responder: the far end of the core's d_* MMU interface.

---
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the core's d_* interface.
// Serves loads from a direct-mapped one-word-per-line cache. Misses start a
// line fill from the backing port. Stores write through to the backing port
// and update the line only when it already holds that address. All d_*
// responses are registered and appear in the cycle after the request.
module dmem_responder #(
  parameter int LINES   = 64,
  parameter int SEG_LSB = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wr_data,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [2:0]  d_trd,
  output logic [31:0] d_rd_data,
  output logic        d_miss,
  output logic        d_segfault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_next;

  // Cache storage: valid bits are reset, data/tag arrays are not.
  logic [LINES-1:0] valid;
  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];

  // Request decode.
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       seg;
  logic             req;
  logic             seg_err;
  logic             legal;
  logic             hit;

  assign idx = d_addr[2 +: IDX_W];
  assign tag = d_addr[31 -: TAG_W];
  assign seg = d_addr[SEG_LSB +: 3];
  assign req = d_rd | d_wr;

  // Thread 0 may touch any segment; other threads only their own.
  assign seg_err = req & ((d_rd & d_wr)
                        | (d_addr[1:0] != 2'b00)
                        | (d_addr[31:SEG_LSB+3] != '0)
                        | ((d_trd != 3'd0) && (seg != d_trd)));
  assign legal   = req & ~seg_err;
  assign hit     = valid[idx] && (tag_mem[idx] == tag);

  // Line being filled is identified by the held backing address.
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign fill_idx = mem_addr[2 +: IDX_W];
  assign fill_tag = mem_addr[31 -: TAG_W];

  // Per-cycle decisions taken by the FSM.
  logic miss_next;
  logic load_hit;
  logic start_fill;
  logic start_write;
  logic fill_done;
  logic txn_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next  = state;
    miss_next   = 1'b0;
    load_hit    = 1'b0;
    start_fill  = 1'b0;
    start_write = 1'b0;
    fill_done   = 1'b0;
    txn_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (legal) begin
          if (d_rd) begin
            if (hit) begin
              load_hit = 1'b1;
            end else begin
              miss_next  = 1'b1;
              start_fill = 1'b1;
              state_next = FILL;
            end
          end else begin
            start_write = 1'b1;
            state_next  = WRITE;
          end
        end
      end
      FILL: begin
        miss_next = legal;
        if (mem_ack) begin
          fill_done  = 1'b1;
          txn_done   = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        miss_next = legal;
        if (mem_ack) begin
          txn_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered core-side responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rd_data  <= '0;
      d_miss     <= 1'b0;
      d_segfault <= 1'b0;
    end else begin
      d_miss     <= miss_next;
      d_segfault <= seg_err;
      if (load_hit) d_rd_data <= data_mem[idx];
    end
  end

  // Backing port: request is launched from IDLE and held until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start_fill || start_write) begin
      mem_req   <= 1'b1;
      mem_we    <= start_write;
      mem_addr  <= {d_addr[31:2], 2'b00};
      mem_wdata <= d_wr_data;
    end else if (txn_done) begin
      mem_req   <= 1'b0;
    end
  end

  // Line valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid           <= '0;
    else if (fill_done) valid[fill_idx] <= 1'b1;
  end

  // Line data and tags: fill installs a line, a store hit updates its word.
  always_ff @(posedge clk) begin
    // NOTE: arrays carry no reset; the cleared valid bits make their
    // power-up contents unobservable.
    if (fill_done) begin
      data_mem[fill_idx] <= mem_rdata;
      tag_mem[fill_idx]  <= fill_tag;
    end else if (start_write && hit) begin
      data_mem[idx] <= d_wr_data;
    end
  end

endmodule
